shift_pattern_sequencer: RTL

- Upstream driver for the 4-bit shift_register.
- Accepts a parallel pattern command over a valid/ready handshake and serialises it onto the register's din/en/dir inputs.
- Bit order is chosen so that, after a full-width command, the register's q equals cmd_data for either direction.
- Emits a done pulse when the pattern has been fully shifted out; sits between the AXI register file and the shift register.

---
 rtl/shift_seq_if.sv | 39 +++
 rtl/shift_pattern_sequencer.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/shift_seq_if.sv
// Command and shift-register bus between a pattern master and shift_pattern_sequencer.
// SHIFT_SEQ_ABORT_EN adds the abort request and aborted status signals.
interface shift_seq_if #(
    parameter int W     = 4,
    parameter int LEN_W = 3
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [W-1:0]     cmd_data;
    logic [LEN_W-1:0] cmd_len;
    logic             cmd_dir;
    logic             sr_din;
    logic             sr_en;
    logic             sr_dir;
    logic             busy;
    logic             done;
`ifdef SHIFT_SEQ_ABORT_EN
    logic             abort;
    logic             aborted;
`endif

    modport master (
        output cmd_valid, cmd_data, cmd_len, cmd_dir,
`ifdef SHIFT_SEQ_ABORT_EN
        output abort,
        input  aborted,
`endif
        input  cmd_ready, sr_din, sr_en, sr_dir, busy, done
    );

    modport slave (
        input  cmd_valid, cmd_data, cmd_len, cmd_dir,
`ifdef SHIFT_SEQ_ABORT_EN
        input  abort,
        output aborted,
`endif
        output cmd_ready, sr_din, sr_en, sr_dir, busy, done
    );
endinterface

// File: rtl/shift_pattern_sequencer.sv
// Serialises a parallel pattern command onto a shift register's din/en/dir inputs.
// Optional SHIFT_SEQ_ABORT_EN adds an abort request that cuts a running shift short.
//
// state | meaning
// IDLE  | cmd_ready high, waiting for a command
// SHIFT | one pattern bit per cycle with sr_en high
// DONE  | single-cycle done pulse, busy still high
module shift_pattern_sequencer #(
    parameter int W     = 4,
    parameter int LEN_W = 3
) (
    input  logic      clk,
    input  logic      rst_n,
    shift_seq_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state, state_nxt;
    logic [W-1:0]     pat, pat_nxt;
    logic [LEN_W-1:0] cnt, cnt_nxt;
    logic [LEN_W-1:0] len_eff;
    logic [LEN_W-1:0] pad;
    logic [W-1:0]     aligned;
    logic             accept;
    logic             stop;
    logic             ready_nxt, din_nxt, en_nxt, dir_nxt, busy_nxt, done_nxt;
`ifdef SHIFT_SEQ_ABORT_EN
    logic             aborted_nxt;
`endif

    assign accept = (state == IDLE) && bus.cmd_valid && bus.cmd_ready;

    // Left shifts go MSB-first from bit L-1, so the pattern is pre-aligned to the top.
    always_comb begin
        len_eff = (bus.cmd_len > LEN_W'(W)) ? LEN_W'(W) : bus.cmd_len;
        pad     = LEN_W'(W) - len_eff;
        aligned = bus.cmd_data << pad;
    end

    always_comb begin
        state_nxt = state;
        pat_nxt   = pat;
        cnt_nxt   = cnt;
        ready_nxt = 1'b0;
        din_nxt   = 1'b0;
        en_nxt    = 1'b0;
        dir_nxt   = bus.sr_dir;
        busy_nxt  = 1'b0;
        done_nxt  = 1'b0;
        stop      = 1'b0;
`ifdef SHIFT_SEQ_ABORT_EN
        aborted_nxt = 1'b0;
`endif
        case (state)
            IDLE: begin
                ready_nxt = 1'b1;
                if (accept) begin
                    ready_nxt = 1'b0;
                    busy_nxt  = 1'b1;
                    dir_nxt   = bus.cmd_dir;
                    if (len_eff == '0) begin
                        state_nxt = DONE;
                        done_nxt  = 1'b1;
                    end else begin
                        state_nxt = SHIFT;
                        en_nxt    = 1'b1;
                        cnt_nxt   = len_eff - 1'b1;
                        if (bus.cmd_dir) begin
                            din_nxt = bus.cmd_data[0];
                            pat_nxt = bus.cmd_data >> 1;
                        end else begin
                            din_nxt = aligned[W-1];
                            pat_nxt = aligned << 1;
                        end
                    end
                end
            end
            SHIFT: begin
                busy_nxt = 1'b1;
`ifdef SHIFT_SEQ_ABORT_EN
                stop = (cnt == '0) || bus.abort;
`else
                stop = (cnt == '0);
`endif
                if (stop) begin
                    state_nxt = DONE;
                    done_nxt  = 1'b1;
                    pat_nxt   = '0;
                    cnt_nxt   = '0;
`ifdef SHIFT_SEQ_ABORT_EN
                    aborted_nxt = bus.abort;
`endif
                end else begin
                    cnt_nxt = cnt - 1'b1;
                    en_nxt  = 1'b1;
                    if (bus.sr_dir) begin
                        din_nxt = pat[0];
                        pat_nxt = pat >> 1;
                    end else begin
                        din_nxt = pat[W-1];
                        pat_nxt = pat << 1;
                    end
                end
            end
            DONE: begin
                state_nxt = IDLE;
                ready_nxt = 1'b1;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            pat           <= '0;
            cnt           <= '0;
            bus.cmd_ready <= 1'b0;
            bus.sr_din    <= 1'b0;
            bus.sr_en     <= 1'b0;
            bus.sr_dir    <= 1'b0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
        end else begin
            state         <= state_nxt;
            pat           <= pat_nxt;
            cnt           <= cnt_nxt;
            bus.cmd_ready <= ready_nxt;
            bus.sr_din    <= din_nxt;
            bus.sr_en     <= en_nxt;
            bus.sr_dir    <= dir_nxt;
            bus.busy      <= busy_nxt;
            bus.done      <= done_nxt;
        end
    end

`ifdef SHIFT_SEQ_ABORT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.aborted <= 1'b0;
        end else begin
            bus.aborted <= aborted_nxt;
        end
    end
`endif
endmodule
